// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch-side, load/store-side and RAM-side
// signals of the memory arbiter. The arbiter connects through the slave
// modport; the requesters and the RAM model connect through master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // instruction-fetch requester
  logic              if_re;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_data;
  logic              if_busy;
  logic              if_done;

  // load/store requester
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SEL_W-1:0]  mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busy;
  logic              mem_done;

  // shared RAM port
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [SEL_W-1:0]  ram_sel;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  if_re, if_addr, if_flush,
    output if_data, if_busy, if_done,
    input  mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
    output mem_rdata, mem_busy, mem_done,
    output ram_req, ram_we, ram_addr, ram_wdata, ram_sel,
    input  ram_rdata, ram_ack
  );

  modport master (
    output if_re, if_addr, if_flush,
    input  if_data, if_busy, if_done,
    output mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
    input  mem_rdata, mem_busy, mem_done,
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_sel,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle-ack RAM port between an instruction
// fetch requester and a load/store requester. One access is in flight at a
// time; the request fields are captured at grant and held on the RAM port
// until ram_ack. Completion is signalled by a one-cycle done pulse to the
// owner together with registered read data.
//
// Optional feature: define MEM_ARB_RR_EN to resolve simultaneous requests
// round-robin (history bit, MEM favoured after reset). Without it MEM always
// wins over IF.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t            state_q;
  logic              ramReq_q;
  logic              ramWe_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic [DATA_W-1:0] ramWdata_q;
  logic [SEL_W-1:0]  ramSel_q;
  logic [DATA_W-1:0] ifData_q;
  logic [DATA_W-1:0] memRdata_q;
  logic              ifDone_q;
  logic              memDone_q;
  logic              busy_q;
  // set once a flush has been seen during the current fetch
  logic              flushSeen_q;
`ifdef MEM_ARB_RR_EN
  // 1 after a MEM grant, so IF wins the next tie; 0 after an IF grant/reset
  logic              preferIf_q;
`endif

  logic memPending_d;
  logic ifPending_d;
  logic grantMem_d;
  logic grantIf_d;
  logic fetchDiscard_d;

  // Grant decision for the coming edge; only meaningful while IDLE
  always_comb begin
    memPending_d = bus.mem_re | bus.mem_we;
    ifPending_d  = bus.if_re & ~bus.if_flush;
    grantMem_d   = 1'b0;
    grantIf_d    = 1'b0;
    if (state_q == IDLE) begin
`ifdef MEM_ARB_RR_EN
      if (memPending_d && ifPending_d) begin
        grantMem_d = ~preferIf_q;
        grantIf_d  = preferIf_q;
      end else begin
        grantMem_d = memPending_d;
        grantIf_d  = ifPending_d;
      end
`else
      grantMem_d = memPending_d;
      grantIf_d  = ifPending_d & ~memPending_d;
`endif
    end
    fetchDiscard_d = flushSeen_q | bus.if_flush;
  end

  // Arbiter state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ramReq_q    <= 1'b0;
      ramWe_q     <= 1'b0;
      ramAddr_q   <= '0;
      ramWdata_q  <= '0;
      ramSel_q    <= '0;
      ifData_q    <= '0;
      memRdata_q  <= '0;
      ifDone_q    <= 1'b0;
      memDone_q   <= 1'b0;
      busy_q      <= 1'b0;
      flushSeen_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      preferIf_q  <= 1'b0;
`endif
    end else begin
      ifDone_q  <= 1'b0;
      memDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantMem_d) begin
            state_q    <= MEM_ACC;
            ramReq_q   <= 1'b1;
            ramWe_q    <= bus.mem_we;
            ramAddr_q  <= bus.mem_addr;
            ramWdata_q <= bus.mem_wdata;
            ramSel_q   <= bus.mem_sel;
            busy_q     <= 1'b1;
`ifdef MEM_ARB_RR_EN
            preferIf_q <= 1'b1;
`endif
          end else if (grantIf_d) begin
            state_q     <= IF_ACC;
            ramReq_q    <= 1'b1;
            ramWe_q     <= 1'b0;
            ramAddr_q   <= bus.if_addr;
            ramWdata_q  <= '0;
            ramSel_q    <= '1;
            busy_q      <= 1'b1;
            flushSeen_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            preferIf_q  <= 1'b0;
`endif
          end
        end
        IF_ACC: begin
          if (bus.if_flush) begin
            flushSeen_q <= 1'b1;
          end
          if (bus.ram_ack) begin
            state_q  <= IDLE;
            ramReq_q <= 1'b0;
            busy_q   <= 1'b0;
            if (!fetchDiscard_d) begin
              ifData_q <= bus.ram_rdata;
              ifDone_q <= 1'b1;
            end
          end
        end
        MEM_ACC: begin
          if (bus.ram_ack) begin
            state_q   <= IDLE;
            ramReq_q  <= 1'b0;
            busy_q    <= 1'b0;
            memDone_q <= 1'b1;
            if (!ramWe_q) begin
              memRdata_q <= bus.ram_rdata;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          ramReq_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_req   = ramReq_q;
  assign bus.ram_we    = ramWe_q;
  assign bus.ram_addr  = ramAddr_q;
  assign bus.ram_wdata = ramWdata_q;
  assign bus.ram_sel   = ramSel_q;
  assign bus.if_data   = ifData_q;
  assign bus.if_done   = ifDone_q;
  assign bus.if_busy   = busy_q;
  assign bus.mem_rdata = memRdata_q;
  assign bus.mem_done  = memDone_q;
  assign bus.mem_busy  = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter kept in the bench.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  // 10 ns clock
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nVectors = 0;
  int nFail    = 0;
  bit checkEn  = 1'b0;

  // transaction-level model: who owns the RAM (0 none, 1 fetch, 2 load/store)
  // and the captured request that must sit on the RAM port meanwhile
  int          owner = 0;
  logic [AW-1:0] curAddr = '0;
  logic [DW-1:0] curWdata = '0;
  logic [SW-1:0] curSel = '0;
  bit          curWe = 1'b0;
  bit          curFlushed = 1'b0;
  logic [DW-1:0] expIfData = '0;
  logic [DW-1:0] expMemRdata = '0;
  bit          expIfDone = 1'b0;
  bit          expMemDone = 1'b0;
`ifdef MEM_ARB_RR_EN
  bit          preferIf = 1'b0;
`endif
  int          waitLeft = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nVectors++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  function automatic int pickWait();
    if ($urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  // Advance the model across the coming clock edge using the inputs now driven
  task automatic modelStep();
    bit memReq, ifReq, memWins;
    expIfDone  = 1'b0;
    expMemDone = 1'b0;
    if (rst) begin
      owner       = 0;
      expIfData   = '0;
      expMemRdata = '0;
`ifdef MEM_ARB_RR_EN
      preferIf    = 1'b0;
`endif
    end else if (owner == 0) begin
      memReq = bus.mem_re | bus.mem_we;
      ifReq  = bus.if_re & ~bus.if_flush;
`ifdef MEM_ARB_RR_EN
      memWins = memReq && (!ifReq || !preferIf);
`else
      memWins = memReq;
`endif
      if (memWins) begin
        owner    = 2;
        curAddr  = bus.mem_addr;
        curWdata = bus.mem_wdata;
        curSel   = bus.mem_sel;
        curWe    = bus.mem_we;
        waitLeft = pickWait();
`ifdef MEM_ARB_RR_EN
        preferIf = 1'b1;
`endif
      end else if (ifReq) begin
        owner      = 1;
        curAddr    = bus.if_addr;
        curWdata   = '0;
        curSel     = '1;
        curWe      = 1'b0;
        curFlushed = 1'b0;
        waitLeft   = pickWait();
`ifdef MEM_ARB_RR_EN
        preferIf   = 1'b0;
`endif
      end
    end else begin
      if (owner == 1 && bus.if_flush) curFlushed = 1'b1;
      if (bus.ram_ack) begin
        if (owner == 1) begin
          if (!curFlushed) begin
            expIfData = bus.ram_rdata;
            expIfDone = 1'b1;
          end
        end else begin
          if (!curWe) expMemRdata = bus.ram_rdata;
          expMemDone = 1'b1;
        end
        owner = 0;
      end
    end
  endtask

  // Apply the currently driven inputs for one clock and move to mid-cycle
  task automatic applyStimulus();
    modelStep();
    @(negedge clk);
    #1;
  endtask

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ram_req",   64'(bus.ram_req),   64'(owner != 0));
      checkOutput("if_busy",   64'(bus.if_busy),   64'(owner != 0));
      checkOutput("mem_busy",  64'(bus.mem_busy),  64'(owner != 0));
      checkOutput("if_done",   64'(bus.if_done),   64'(expIfDone));
      checkOutput("mem_done",  64'(bus.mem_done),  64'(expMemDone));
      checkOutput("if_data",   64'(bus.if_data),   64'(expIfData));
      checkOutput("mem_rdata", 64'(bus.mem_rdata), 64'(expMemRdata));
      if (owner != 0) begin
        checkOutput("ram_we",    64'(bus.ram_we),    64'(curWe));
        checkOutput("ram_addr",  64'(bus.ram_addr),  64'(curAddr));
        checkOutput("ram_wdata", 64'(bus.ram_wdata), 64'(curWdata));
        checkOutput("ram_sel",   64'(bus.ram_sel),   64'(curSel));
      end
    end
  end

  initial begin
    logic [AW-1:0] firstAddr, secondAddr;
    logic [DW-1:0] memLast, ifLast;
    bit memFirst;
    bit ifActive, memActive;
    int memKind;

`ifdef MEM_ARB_RR_EN
    memFirst = 1'b0;
`else
    memFirst = 1'b1;
`endif

    rst           = 1'b1;
    bus.if_re     = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_sel   = '0;
    bus.ram_rdata = '0;
    bus.ram_ack   = 1'b0;
    checkEn       = 1'b1;
    applyStimulus();
    applyStimulus();

    // reset state, literal
    checkOutput("reset ram_req",   64'(bus.ram_req),   64'h0);
    checkOutput("reset ram_we",    64'(bus.ram_we),    64'h0);
    checkOutput("reset ram_addr",  64'(bus.ram_addr),  64'h0);
    checkOutput("reset ram_wdata", 64'(bus.ram_wdata), 64'h0);
    checkOutput("reset ram_sel",   64'(bus.ram_sel),   64'h0);
    checkOutput("reset if_data",   64'(bus.if_data),   64'h0);
    checkOutput("reset mem_rdata", 64'(bus.mem_rdata), 64'h0);
    checkOutput("reset busy",      64'({bus.if_busy, bus.mem_busy, bus.if_done, bus.mem_done}), 64'h0);
    rst = 1'b0;

    // zero-wait fetch: request cycle, RAM cycle, done in the third cycle
    bus.if_re   = 1'b1;
    bus.if_addr = 32'h100;
    applyStimulus();
    checkOutput("fetch ram_req",  64'(bus.ram_req),  64'h1);
    checkOutput("fetch ram_addr", 64'(bus.ram_addr), 64'h100);
    checkOutput("fetch ram_sel",  64'(bus.ram_sel),  64'hF);
    checkOutput("fetch ram_we",   64'(bus.ram_we),   64'h0);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h00A00093;
    applyStimulus();
    checkOutput("fetch if_done", 64'(bus.if_done), 64'h1);
    checkOutput("fetch if_data", 64'(bus.if_data), 64'h00A00093);
    checkOutput("fetch if_busy", 64'(bus.if_busy), 64'h0);
    bus.if_re   = 1'b0;
    bus.ram_ack = 1'b0;
    applyStimulus();
    checkOutput("fetch done one cycle", 64'(bus.if_done), 64'h0);

    // a MEM load, so the round-robin history points at IF next
    bus.mem_re   = 1'b1;
    bus.mem_addr = 32'h40;
    bus.mem_sel  = 4'hF;
    applyStimulus();
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h0BADF00D;
    applyStimulus();
    checkOutput("load mem_rdata", 64'(bus.mem_rdata), 64'h0BADF00D);

    // simultaneous requests issued in the done cycle
    bus.ram_ack  = 1'b0;
    bus.if_re    = 1'b1;
    bus.if_addr  = 32'h300;
    bus.mem_re   = 1'b1;
    bus.mem_addr = 32'h200;
    firstAddr    = memFirst ? 32'h200 : 32'h300;
    secondAddr   = memFirst ? 32'h300 : 32'h200;
    applyStimulus();
    checkOutput("simul first addr", 64'(bus.ram_addr), 64'(firstAddr));
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hCAFEF00D;
    applyStimulus();
    checkOutput("simul first done", 64'({bus.mem_done, bus.if_done}), memFirst ? 64'h2 : 64'h1);
    if (memFirst) bus.mem_re = 1'b0;
    else bus.if_re = 1'b0;
    bus.ram_ack = 1'b0;
    applyStimulus();
    checkOutput("simul second addr", 64'(bus.ram_addr), 64'(secondAddr));
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h11112222;
    applyStimulus();
    checkOutput("simul second done", 64'({bus.mem_done, bus.if_done}), memFirst ? 64'h1 : 64'h2);
    bus.if_re   = 1'b0;
    bus.mem_re  = 1'b0;
    bus.ram_ack = 1'b0;
    memLast = memFirst ? 32'hCAFEF00D : 32'h11112222;
    ifLast  = memFirst ? 32'h11112222 : 32'hCAFEF00D;

    // store with four wait cycles: fields held for five RAM cycles
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h14;
    bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_sel   = 4'h3;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      checkOutput("store ram_fields", 64'({bus.ram_req, bus.ram_we, bus.ram_sel, bus.ram_addr[7:0], bus.ram_wdata}),
                  64'({1'b1, 1'b1, 4'h3, 8'h14, 32'hDEADBEEF}));
      bus.ram_ack   = (i == 4);
      bus.ram_rdata = 32'h99999999;
      applyStimulus();
    end
    checkOutput("store mem_done",  64'(bus.mem_done),  64'h1);
    checkOutput("store mem_rdata", 64'(bus.mem_rdata), 64'(memLast));
    bus.mem_we  = 1'b0;
    bus.ram_ack = 1'b0;
    applyStimulus();
    checkOutput("store done one cycle", 64'(bus.mem_done), 64'h0);

    // flush during a fetch: access completes silently
    bus.if_re   = 1'b1;
    bus.if_addr = 32'h180;
    applyStimulus();
    bus.if_flush = 1'b1;
    bus.if_re    = 1'b0;
    applyStimulus();
    bus.if_flush  = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h12345678;
    applyStimulus();
    checkOutput("flush if_done", 64'(bus.if_done), 64'h0);
    checkOutput("flush if_data", 64'(bus.if_data), 64'(ifLast));
    checkOutput("flush if_busy", 64'(bus.if_busy), 64'h0);
    bus.ram_ack = 1'b0;
    bus.if_re   = 1'b1;
    bus.if_addr = 32'h184;
    applyStimulus();
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h55AA55AA;
    applyStimulus();
    checkOutput("post-flush if_data", 64'(bus.if_data), 64'h55AA55AA);

    // flush while IDLE blocks the fetch grant for that cycle
    bus.ram_ack  = 1'b0;
    bus.if_addr  = 32'h188;
    bus.if_flush = 1'b1;
    applyStimulus();
    checkOutput("idle flush blocks", 64'(bus.ram_req), 64'h0);
    bus.if_flush = 1'b0;
    applyStimulus();
    checkOutput("idle flush release", 64'(bus.ram_addr), 64'h188);
    bus.ram_ack = 1'b1;
    applyStimulus();
    bus.if_re   = 1'b0;
    bus.ram_ack = 1'b0;

    // reset in the middle of a load, then a late ack
    bus.mem_re   = 1'b1;
    bus.mem_addr = 32'h88;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("midrst outputs", 64'({bus.ram_req, bus.ram_we, bus.if_busy, bus.mem_busy, bus.if_done, bus.mem_done}), 64'h0);
    checkOutput("midrst ram_addr", 64'(bus.ram_addr), 64'h0);
    checkOutput("midrst data", 64'({bus.if_data, bus.mem_rdata}), 64'h0);
    rst         = 1'b0;
    bus.mem_re  = 1'b0;
    bus.ram_ack = 1'b1;
    applyStimulus();
    checkOutput("late ack no done", 64'({bus.ram_req, bus.mem_busy, bus.mem_done, bus.if_done}), 64'h0);
    bus.ram_ack = 1'b0;

    // randomized traffic
    ifActive  = 1'b0;
    memActive = 1'b0;
    memKind   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);

      if (expIfDone) ifActive = 1'b0;
      if (!ifActive && $urandom_range(0, 3) == 0) begin
        ifActive    = 1'b1;
        bus.if_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
      end
      bus.if_flush = 1'b0;
      if (owner == 1 && $urandom_range(0, 9) == 0) begin
        bus.if_flush = 1'b1;
        ifActive     = 1'b0;
      end else if (owner == 0 && $urandom_range(0, 11) == 0) begin
        bus.if_flush = 1'b1;
      end
      bus.if_re = ifActive;

      if (expMemDone) memActive = 1'b0;
      if (!memActive && $urandom_range(0, 2) == 0) begin
        memActive     = 1'b1;
        memKind       = int'($urandom_range(0, 2));
        bus.mem_addr  = $urandom();
        bus.mem_wdata = $urandom();
        bus.mem_sel   = 4'($urandom_range(0, 15));
      end
      bus.mem_re = memActive && (memKind != 1);
      bus.mem_we = memActive && (memKind != 0);

      if (owner != 0) begin
        bus.ram_ack = (waitLeft == 0);
        if (waitLeft > 0) waitLeft--;
      end else begin
        bus.ram_ack = ($urandom_range(0, 5) == 0);
      end
      bus.ram_rdata = $urandom();
      applyStimulus();
    end

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
